// File: rtl/rc_filter_sequencer.sv
// Time-multiplexed first-order RC filter: one subtract/multiply/accumulate unit
// sweeps NUM_CH low-/high-pass channels per sample strobe and publishes them together.
module rc_filter_sequencer #(
  parameter  int NUM_CH = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   I_RSTn,
  input  logic                   audio_clk_en,
  input  logic [NUM_CH*16-1:0]   in_flat,
  output logic [NUM_CH*16-1:0]   out_flat,
  output logic                   done,
  output logic                   busy,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic [15:0]            cfg_alpha,
  input  logic                   cfg_hp,
  output logic                   cfg_ready,
  output logic                   overrun,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

  state_t                   st;
  logic [CH_W-1:0]          ch;
  logic [NUM_CH-1:0][15:0]  in_lat, y_mem, alpha_mem, shadow, shadow_nx, out_r;
  logic [NUM_CH-1:0]        hp_mem;

  logic signed [15:0]       x_r, y_r;
  logic signed [16:0]       d_r;
  logic [15:0]              a_r;
  logic                     hp_r;

  logic signed [33:0]       prod;
  logic signed [16:0]       p_shr, y_new, hp_diff;
  logic signed [15:0]       y_sat, res;
  logic                     addr_ok, last_ch;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)       return 16'sh7fff;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return 16'(v);
  endfunction

  // alpha is unsigned Q0.16, so it enters the signed multiply zero-extended
  assign prod    = 34'(d_r) * 34'($signed({1'b0, a_r}));
  assign p_shr   = 17'(prod >>> 16);
  assign y_new   = $signed({y_r[15], y_r}) + p_shr;
  assign y_sat   = sat16(y_new);
  assign hp_diff = $signed({x_r[15], x_r}) - $signed({y_sat[15], y_sat});
  assign res     = hp_r ? sat16(hp_diff) : y_sat;

  always_comb begin
    shadow_nx     = shadow;
    shadow_nx[ch] = res;
  end

  assign addr_ok   = ({1'b0, cfg_addr} < (CH_W+1)'(NUM_CH));
  assign last_ch   = (ch == CH_W'(NUM_CH-1));
  assign cfg_ready = !busy;
  assign out_flat  = out_r;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      st        <= IDLE;
      ch        <= '0;
      in_lat    <= '0;
      y_mem     <= '0;
      alpha_mem <= '0;
      hp_mem    <= '0;
      shadow    <= '0;
      out_r     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      d_r       <= '0;
      a_r       <= '0;
      hp_r      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      // the publish cycle counts as busy, so a strobe landing on it is dropped
      if (audio_clk_en && (busy || done)) overrun <= 1'b1;
      if (cfg_we) begin
        if (busy || !addr_ok) cfg_err <= 1'b1;
        else begin
          alpha_mem[cfg_addr] <= cfg_alpha;
          hp_mem[cfg_addr]    <= cfg_hp;
        end
      end
      case (st)
        IDLE: if (audio_clk_en && !done) begin
          in_lat <= in_flat;
          busy   <= 1'b1;
          ch     <= '0;
          st     <= LOAD;
        end
        LOAD: begin
          x_r  <= $signed(in_lat[ch]);
          y_r  <= $signed(y_mem[ch]);
          d_r  <= $signed({in_lat[ch][15], in_lat[ch]}) - $signed({y_mem[ch][15], y_mem[ch]});
          a_r  <= alpha_mem[ch];
          hp_r <= hp_mem[ch];
          st   <= CALC;
        end
        CALC: begin
          y_mem[ch] <= y_sat;
          shadow    <= shadow_nx;
          if (last_ch) begin
            out_r <= shadow_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            st    <= IDLE;
          end else begin
            ch <= ch + 1'b1;
            st <= LOAD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_filter_sequencer.sv
// Directed bench for rc_filter_sequencer; six channels so an out-of-range
// cfg_addr is representable on the CH_W-bit port.
module tb_rc_filter_sequencer;
  localparam int NUM_CH = 6;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int LAT    = 2*NUM_CH;

  logic                  clk = 1'b0;
  logic                  I_RSTn = 1'b0;
  logic                  audio_clk_en = 1'b0;
  logic [NUM_CH*16-1:0]  in_flat = '0;
  logic [NUM_CH*16-1:0]  out_flat;
  logic                  done, busy, cfg_ready, overrun, cfg_err;
  logic                  cfg_we = 1'b0;
  logic [CH_W-1:0]       cfg_addr = '0;
  logic [15:0]           cfg_alpha = '0;
  logic                  cfg_hp = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat, ndone;

  rc_filter_sequencer #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en),
    .in_flat(in_flat), .out_flat(out_flat), .done(done), .busy(busy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_alpha(cfg_alpha), .cfg_hp(cfg_hp),
    .cfg_ready(cfg_ready), .overrun(overrun), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [15:0] ch_out(input int k);
    return out_flat[16*k +: 16];
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int k, input int v);
    in_flat[16*k +: 16] = 16'(v);
  endtask

  // starts and ends on a falling edge
  task automatic cfg(input int a, input int alpha, input logic hp);
    cfg_we = 1'b1; cfg_addr = CH_W'(a); cfg_alpha = 16'(alpha); cfg_hp = hp;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // returns cycles from the sampling edge to done; leaves us on the done cycle
  task automatic sweep(output int l);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0; cfg_we = 1'b0;
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) c++;
    end
  endtask

  int lp_exp[3] = '{5000, 7500, 8750};
  int hp_exp[3] = '{5000, 2500, 1250};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", |out_flat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_ovr", overrun, 0);
    chk("rst_cerr", cfg_err, 0);
    I_RSTn = 1'b1;
    @(negedge clk);

    // LP ch0 / HP ch1 at alpha 0.5
    cfg(0, 32768, 1'b0);
    cfg(1, 32768, 1'b1);
    set_in(0, 10000); set_in(1, 10000);
    for (int i = 0; i < 3; i++) begin
      sweep(lat);
      chk("lat", lat, LAT);
      chk("lp_ch0", ch_out(0), lp_exp[i]);
      chk("hp_ch1", ch_out(1), hp_exp[i]);
      chk("ch2_idle", ch_out(2), 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_clr", busy, 0);
    end

    // drive ch2 state up; 30000*65535>>16 floors to 29999 and stays there
    cfg(2, 65535, 1'b0);
    set_in(2, 30000);
    sweep(lat);
    chk("lp_ch2_a", ch_out(2), 29999);
    @(negedge clk);
    sweep(lat);
    chk("lp_ch2_b", ch_out(2), 29999);
    @(negedge clk);

    // HP with alpha 0: -32768-29999 saturates; LP toward -32768 lands exactly
    cfg(2, 0, 1'b1);
    cfg(3, 65535, 1'b0);
    set_in(2, -32768); set_in(3, -32768);
    sweep(lat);
    chk("hp_sat_ch2", ch_out(2), -32768);
    chk("lp_neg_ch3", ch_out(3), -32768);
    @(negedge clk);
    cfg(2, 0, 1'b0);
    sweep(lat);
    chk("hp_keeps_state", ch_out(2), 29999);
    chk("no_ovr_yet", overrun, 0);
    chk("no_cerr_yet", cfg_err, 0);
    @(negedge clk);

    // second strobe three edges into the sweep
    cfg(4, 32768, 1'b0);
    set_in(4, 20000);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (2) @(negedge clk);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    count_done(40, ndone);
    chk("ovr_one_done", ndone, 1);
    chk("ovr_ch4", ch_out(4), 10000);
    chk("ovr_flag", overrun, 1);

    // strobe on the done cycle is dropped
    sweep(lat);
    chk("ch4_second", ch_out(4), 15000);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    chk("done_strobe_drop", busy, 0);
    @(negedge clk);

    // write while busy is rejected
    set_in(5, 20000);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    chk("ready_low", cfg_ready, 0);
    cfg(5, 65535, 1'b0);
    chk("cerr_busy", cfg_err, 1);
    count_done(40, ndone);
    sweep(lat);
    chk("rejected_ch5", ch_out(5), 0);
    @(negedge clk);

    // reset five cycles into a sweep
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (4) @(negedge clk);
    #2 I_RSTn = 1'b0;
    #1;
    chk("mid_rst_out", |out_flat, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_cerr", cfg_err, 0);
    @(negedge clk);
    I_RSTn = 1'b1;
    count_done(30, ndone);
    chk("no_done_after_rst", ndone, 0);

    cfg(7, 65535, 1'b0);
    chk("cerr_addr", cfg_err, 1);

    // config + strobe on the same cycle; in_flat changes afterwards are ignored
    set_in(0, 10000);
    cfg_we = 1'b1; cfg_addr = '0; cfg_alpha = 16'd32768; cfg_hp = 1'b0;
    audio_clk_en = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; audio_clk_en = 1'b0;
    set_in(0, 0);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("same_cyc_lat", lat, LAT);
    chk("same_cyc_ch0", ch_out(0), 5000);
    chk("post_rst_ch5", ch_out(5), 0);
    chk("post_rst_ch1", ch_out(1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
